// File: rtl/tcp_pkt_cap_if.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_pkt_cap_if
//  Purpose  : Bundles the packet stream sunk by the capture block and the
//             cbus register/RAM access port into one interface.
//  Modports : master - drives the stream and cbus requests (source / host)
//             slave  - the capture block (sinks beats, answers cbus)
//  Signals  : rx_pkt_vld/rdy/dat/msg  packet beat, msg[0] = end-of-packet
//             cbus_req/rw/addr/wdata  request, held until cbus_ack
//             cbus_ack/rdata          one-cycle acknowledge with read data
//  Revision : 1.0 - initial release
// ============================================================================
interface tcp_pkt_cap_if #(
  parameter int DAT_WID   = 256,
  parameter int MSG_WID   = 20,
  parameter int CBUS_AWID = 16,
  parameter int CBUS_DWID = 32
);
  logic                 rx_pkt_vld;
  logic                 rx_pkt_rdy;
  logic [DAT_WID-1:0]   rx_pkt_dat;
  logic [MSG_WID-1:0]   rx_pkt_msg;

  logic                 cbus_req;
  logic                 cbus_rw;
  logic                 cbus_ack;
  logic [CBUS_AWID-1:0] cbus_addr;
  logic [CBUS_DWID-1:0] cbus_wdata;
  logic [CBUS_DWID-1:0] cbus_rdata;

  modport master (
    output rx_pkt_vld, rx_pkt_dat, rx_pkt_msg,
    output cbus_req, cbus_rw, cbus_addr, cbus_wdata,
    input  rx_pkt_rdy, cbus_ack, cbus_rdata
  );

  modport slave (
    input  rx_pkt_vld, rx_pkt_dat, rx_pkt_msg,
    input  cbus_req, cbus_rw, cbus_addr, cbus_wdata,
    output rx_pkt_rdy, cbus_ack, cbus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/tcp_pkt_cap.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_pkt_cap
//  Purpose  : Packet capture sink. Stores whole packets, starting on a packet
//             boundary, into a 1024-line capture RAM ({msg, dat} per line),
//             exposes the RAM read-only over cbus and keeps packet, beat,
//             drop and minimum inter-packet gap statistics.
//  Ports    : clk, rst          clock, asynchronous active-high reset
//             io_bus            packet stream + cbus (slave modport)
//             i_cfg_cap_start   bit 0 arms capture (level)
//             i_cfg_cap_num     packets to capture, 0 = until RAM full
//             o_stat_state      0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//             o_stat_wptr       beats stored (0..1024)
//             o_stat_pkt_cnt    packets stored
//             o_stat_drop_cnt   beats discarded after capture completed
//             o_stat_gap_min    minimum idle cycles between eop and next beat
//             o_dbg_sig         {state, wptr, in_pkt, zero pad}
//  Revision : 1.0 - initial release
// ============================================================================
module tcp_pkt_cap #(
  parameter int DAT_WID   = 256,
  parameter int MSG_WID   = 20,
  parameter int CBUS_AWID = 16,
  parameter int CBUS_DWID = 32,
  parameter int DBG_WID   = 32
) (
  input  wire logic               clk,
  input  wire logic               rst,
  tcp_pkt_cap_if.slave            io_bus,
  input  wire logic [31:0]        i_cfg_cap_start,
  input  wire logic [31:0]        i_cfg_cap_num,
  output logic [1:0]              o_stat_state,
  output logic [10:0]             o_stat_wptr,
  output logic [31:0]             o_stat_pkt_cnt,
  output logic [31:0]             o_stat_drop_cnt,
  output logic [31:0]             o_stat_gap_min,
  output logic [DBG_WID-1:0]      o_dbg_sig
);

  localparam int c_LINE_W = DAT_WID + MSG_WID;
  localparam int c_DEPTH  = 1024;
  // Number of cbus words that carry line bits; higher word indices read 0.
  localparam int c_NWORDS = (c_LINE_W + CBUS_DWID - 1) / CBUS_DWID;
  localparam int c_PAD_W  = c_NWORDS * CBUS_DWID;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_in_pkt;
  logic [10:0]       r_wptr;
  logic [31:0]       r_pkt_cnt;
  logic [31:0]       r_drop_cnt;
  logic [31:0]       r_gap_min;
  logic [31:0]       r_gap_cnt;
  logic              r_gap_arm;

  logic              w_vld;
  logic              w_eop;
  logic              w_start;
  logic              w_wr_en;
  logic              w_drop;
  logic              w_arm;
  logic              w_last_pkt;
  logic              w_full;
  logic              w_gap_upd;
  logic [10:0]       w_wptr_inc;
  logic [31:0]       w_pkt_cnt_inc;

  assign w_vld         = io_bus.rx_pkt_vld;
  assign w_eop         = io_bus.rx_pkt_msg[0];
  assign w_start       = i_cfg_cap_start[0];
  assign w_wptr_inc    = r_wptr + 11'd1;
  assign w_pkt_cnt_inc = r_pkt_cnt + 32'd1;

  // Completion conditions evaluated for the beat being written this cycle.
  assign w_last_pkt = w_eop && (i_cfg_cap_num != 32'd0) && (w_pkt_cnt_inc == i_cfg_cap_num);
  assign w_full     = (w_wptr_inc == 11'd1024);

  // The block never backpressures.
  assign io_bus.rx_pkt_rdy = 1'b1;

  // --------------------------------------------------------------------------
  // Packet boundary tracker, runs in every state so arming mid-packet waits
  // for the next first beat.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_pkt <= 1'b0;
    end else if (w_vld) begin
      r_in_pkt <= !w_eop;
    end
  end

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_drop      = 1'b0;
    w_arm       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_ARMED;
          w_arm       = 1'b1;
        end
      end
      S_ARMED: begin
        if (!w_start) begin
          w_state_nxt = S_IDLE;
        end else if (w_vld && !r_in_pkt) begin
          // First beat of a fresh packet: it is stored, and a one-beat
          // packet may already complete the capture.
          w_wr_en     = 1'b1;
          w_state_nxt = (w_last_pkt || w_full) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // The beat is stored even when start drops in the same cycle.
        if (w_vld) begin
          w_wr_en = 1'b1;
          if (w_last_pkt || w_full) begin
            w_state_nxt = S_DONE;
          end
        end
        if (!w_start) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_drop = w_vld;
        if (!w_start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Gap measurement. r_gap_cnt is 0 on the cycle after any beat and counts
  // idle cycles from there; r_gap_arm marks that the last stored beat was an
  // eop so the next beat closes a gap.
  // --------------------------------------------------------------------------
  assign w_gap_upd = w_vld && r_gap_arm && (r_state == S_CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= 32'd0;
      r_gap_arm <= 1'b0;
    end else begin
      if (w_vld) begin
        r_gap_cnt <= 32'd0;
      end else if (r_gap_cnt != 32'hFFFF_FFFF) begin
        r_gap_cnt <= r_gap_cnt + 32'd1;
      end

      if (w_arm) begin
        r_gap_arm <= 1'b0;
      end else if (w_wr_en && w_eop) begin
        r_gap_arm <= 1'b1;
      end else if (w_gap_upd) begin
        r_gap_arm <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= 11'd0;
      r_pkt_cnt  <= 32'd0;
      r_drop_cnt <= 32'd0;
      r_gap_min  <= 32'hFFFF_FFFF;
    end else if (w_arm) begin
      r_wptr     <= 11'd0;
      r_pkt_cnt  <= 32'd0;
      r_drop_cnt <= 32'd0;
      r_gap_min  <= 32'hFFFF_FFFF;
    end else begin
      if (w_wr_en) begin
        r_wptr <= w_wptr_inc;
        if (w_eop) begin
          r_pkt_cnt <= w_pkt_cnt_inc;
        end
      end
      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
      if (w_gap_upd && (r_gap_cnt < r_gap_min)) begin
        r_gap_min <= r_gap_cnt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture RAM: simple dual port, write port from the stream, read port
  // from cbus. Read-before-write on the same line returns the old line.
  // --------------------------------------------------------------------------
  logic [c_LINE_W-1:0] r_ram [c_DEPTH];
  logic [c_LINE_W-1:0] r_rd_line;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ram[r_wptr[9:0]] <= {io_bus.rx_pkt_msg, io_bus.rx_pkt_dat};
    end
  end

  // --------------------------------------------------------------------------
  // cbus access pipeline. Accept (N) -> RAM read (N+1) -> word mux + ack
  // (N+2). Writes are acknowledged at N+1 and discarded. r_busy blocks a new
  // accept until the cycle after ack.
  // --------------------------------------------------------------------------
  logic                   r_busy;
  logic                   r_rd_s1;
  logic                   r_rd_s2;
  logic                   r_wr_s1;
  logic [9:0]             r_rd_idx;
  logic [5:0]             r_rd_word;
  logic                   r_ack;
  logic [CBUS_DWID-1:0]   r_rdata;
  logic                   w_accept;
  logic [c_PAD_W-1:0]     w_rd_pad;
  logic [CBUS_DWID-1:0]   w_rd_word_dat;

  assign w_accept = io_bus.cbus_req && !r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_rd_s1   <= 1'b0;
      r_rd_s2   <= 1'b0;
      r_wr_s1   <= 1'b0;
      r_rd_idx  <= 10'd0;
      r_rd_word <= 6'd0;
      r_ack     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_s1 <= w_accept && io_bus.cbus_rw;
      r_wr_s1 <= w_accept && !io_bus.cbus_rw;
      r_rd_s2 <= r_rd_s1;
      r_ack   <= r_wr_s1 || r_rd_s2;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_rd_idx  <= io_bus.cbus_addr[CBUS_AWID-1:6];
        r_rd_word <= io_bus.cbus_addr[5:0];
      end else if (r_wr_s1 || r_rd_s2) begin
        r_busy <= 1'b0;
      end
      if (r_rd_s2) begin
        r_rdata <= w_rd_word_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_rd_s1) begin
      r_rd_line <= r_ram[r_rd_idx];
    end
  end

  // Zero-extend the line to a whole number of words, then pick one word.
  always_comb begin
    w_rd_pad                 = '0;
    w_rd_pad[c_LINE_W-1:0]   = r_rd_line;
    w_rd_word_dat            = '0;
    for (int k = 0; k < c_NWORDS; k++) begin
      if (r_rd_word == 6'(k)) begin
        w_rd_word_dat = w_rd_pad[k*CBUS_DWID +: CBUS_DWID];
      end
    end
  end

  assign io_bus.cbus_ack   = r_ack;
  assign io_bus.cbus_rdata = r_rdata;

  // --------------------------------------------------------------------------
  // Status / debug outputs
  // --------------------------------------------------------------------------
  assign o_stat_state    = r_state;
  assign o_stat_wptr     = r_wptr;
  assign o_stat_pkt_cnt  = r_pkt_cnt;
  assign o_stat_drop_cnt = r_drop_cnt;
  assign o_stat_gap_min  = r_gap_min;
  assign o_dbg_sig       = {r_state, r_wptr, r_in_pkt, {(DBG_WID-14){1'b0}}};

  // Write data and the upper start bits have no function.
  logic w_unused;
  assign w_unused = ^{io_bus.cbus_wdata, i_cfg_cap_start[31:1]};

endmodule
`default_nettype wire

// File: tb/tb_tcp_pkt_cap.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcp_pkt_cap
//  Purpose  : Self-checking bench for tcp_pkt_cap. Beats sent with capture
//             expected are recorded in a reference line array; cbus reads
//             push the expected word into a scoreboard queue that is popped
//             when the acknowledge arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tcp_pkt_cap;

  localparam int DAT_WID = 256;
  localparam int MSG_WID = 20;
  localparam int LINE_W  = DAT_WID + MSG_WID;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_start;
  logic [31:0] cfg_num;
  logic [1:0]  stat_state;
  logic [10:0] stat_wptr;
  logic [31:0] stat_pkt_cnt;
  logic [31:0] stat_drop_cnt;
  logic [31:0] stat_gap_min;
  logic [31:0] dbg_sig;

  always #5 clk = ~clk;

  tcp_pkt_cap_if #(.DAT_WID(DAT_WID), .MSG_WID(MSG_WID), .CBUS_AWID(16), .CBUS_DWID(32)) bus ();

  tcp_pkt_cap #(
    .DAT_WID(DAT_WID), .MSG_WID(MSG_WID), .CBUS_AWID(16), .CBUS_DWID(32), .DBG_WID(32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .io_bus          (bus),
    .i_cfg_cap_start (cfg_start),
    .i_cfg_cap_num   (cfg_num),
    .o_stat_state    (stat_state),
    .o_stat_wptr     (stat_wptr),
    .o_stat_pkt_cnt  (stat_pkt_cnt),
    .o_stat_drop_cnt (stat_drop_cnt),
    .o_stat_gap_min  (stat_gap_min),
    .o_dbg_sig       (dbg_sig)
  );

  int              n_checks = 0;
  int              n_errors = 0;
  int              seq      = 0;
  int              exp_wp   = 0;
  logic [LINE_W-1:0] exp_line [0:1023];
  logic [31:0]     sb_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DAT_WID-1:0] mk_dat(input int n);
    logic [DAT_WID-1:0] d;
    for (int k = 0; k < 8; k++) begin
      d[k*32 +: 32] = (32'(n) * 32'h0100_0193) ^ (32'(k) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_word(input int line, input int w);
    logic [287:0] pad;
    pad             = '0;
    pad[LINE_W-1:0] = exp_line[line];
    if (w < 9) return pad[w*32 +: 32];
    return 32'd0;
  endfunction

  // Drives nb consecutive beats starting at a negedge; last one carries eop
  // when last_eop is set. Captured beats are recorded (up to RAM depth).
  task automatic send_beats(input int nb, input bit last_eop, input bit cap);
    logic eop;
    for (int i = 0; i < nb; i++) begin
      eop             = last_eop && (i == nb - 1);
      bus.rx_pkt_vld  = 1'b1;
      bus.rx_pkt_dat  = mk_dat(seq);
      bus.rx_pkt_msg  = {seq[18:0], eop};
      if (cap && exp_wp < 1024) begin
        exp_line[exp_wp] = {bus.rx_pkt_msg, bus.rx_pkt_dat};
        exp_wp++;
      end
      seq++;
      @(negedge clk);
    end
    bus.rx_pkt_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cbus_rd(input int line, input int w);
    int cyc;
    logic [31:0] expv;
    bus.cbus_req  = 1'b1;
    bus.cbus_rw   = 1'b1;
    bus.cbus_addr = {line[9:0], w[5:0]};
    sb_q.push_back(exp_word(line, w));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cbus_ack && cyc < 20);
    bus.cbus_req = 1'b0;
    expv = sb_q.pop_front();
    if (!bus.cbus_ack) begin
      check("rd_ack_timeout", 64'(bus.cbus_ack), 64'd1);
    end else begin
      check("rd_latency", 64'(cyc), 64'd3);
      check($sformatf("rd_L%0d_W%0d", line, w), 64'(bus.cbus_rdata), 64'(expv));
    end
  endtask

  task automatic cbus_wr(input int line, input int w, input logic [31:0] data);
    int cyc;
    bus.cbus_req   = 1'b1;
    bus.cbus_rw    = 1'b0;
    bus.cbus_addr  = {line[9:0], w[5:0]};
    bus.cbus_wdata = data;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cbus_ack && cyc < 20);
    bus.cbus_req = 1'b0;
    if (!bus.cbus_ack) begin
      check("wr_ack_timeout", 64'(bus.cbus_ack), 64'd1);
    end else begin
      check("wr_latency", 64'(cyc), 64'd2);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_rdy"},   64'(bus.rx_pkt_rdy), 64'd1);
    check({pfx, "_ack"},   64'(bus.cbus_ack),   64'd0);
    check({pfx, "_rdata"}, 64'(bus.cbus_rdata), 64'd0);
    check({pfx, "_state"}, 64'(stat_state),     64'd0);
    check({pfx, "_wptr"},  64'(stat_wptr),      64'd0);
    check({pfx, "_pkt"},   64'(stat_pkt_cnt),   64'd0);
    check({pfx, "_drop"},  64'(stat_drop_cnt),  64'd0);
    check({pfx, "_gap"},   64'(stat_gap_min),   64'hFFFF_FFFF);
    check({pfx, "_dbg"},   64'(dbg_sig),        64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    cfg_start      = 32'd0;
    cfg_num        = 32'd0;
    bus.rx_pkt_vld = 1'b0;
    bus.rx_pkt_dat = '0;
    bus.rx_pkt_msg = '0;
    bus.cbus_req   = 1'b0;
    bus.cbus_rw    = 1'b0;
    bus.cbus_addr  = '0;
    bus.cbus_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // ---- 3 packets x 4 beats, gap 2, cap_num 3 ----
    cfg_num   = 32'd3;
    cfg_start = 32'd1;
    @(negedge clk);
    check("t1_armed", 64'(stat_state), 64'd1);
    exp_wp = 0;
    send_beats(4, 1'b1, 1'b1);
    check("t1_cap_state", 64'(stat_state), 64'd2);
    check("t1_wptr4", 64'(stat_wptr), 64'd4);
    check("t1_pkt1", 64'(stat_pkt_cnt), 64'd1);
    idle(2);
    send_beats(4, 1'b1, 1'b1);
    idle(2);
    send_beats(4, 1'b1, 1'b1);
    check("t1_done", 64'(stat_state), 64'd3);
    check("t1_wptr", 64'(stat_wptr), 64'd12);
    check("t1_pkt", 64'(stat_pkt_cnt), 64'd3);
    check("t1_gap", 64'(stat_gap_min), 64'd2);
    check("t1_drop", 64'(stat_drop_cnt), 64'd0);
    check("t1_dbg", 64'(dbg_sig), 64'({2'd3, 11'd12, 1'b0, 18'd0}));
    cbus_rd(5, 0);
    cbus_rd(5, 8);
    cbus_rd(5, 9);
    cbus_rd(11, 7);
    cbus_wr(5, 0, 32'hDEAD_BEEF);
    cbus_rd(5, 0);
    send_beats(2, 1'b1, 1'b0);
    check("t1_drop2", 64'(stat_drop_cnt), 64'd2);
    check("t1_wptr_hold", 64'(stat_wptr), 64'd12);

    // ---- stop during capture, re-arm clears ----
    cfg_start = 32'd0;
    @(negedge clk);
    check("t5_idle", 64'(stat_state), 64'd0);
    check("t5_hold_wptr", 64'(stat_wptr), 64'd12);
    check("t5_hold_pkt", 64'(stat_pkt_cnt), 64'd3);
    check("t5_hold_drop", 64'(stat_drop_cnt), 64'd2);
    cfg_start = 32'd1;
    @(negedge clk);
    check("t5_rearm", 64'(stat_state), 64'd1);
    check("t5_clr_wptr", 64'(stat_wptr), 64'd0);
    check("t5_clr_pkt", 64'(stat_pkt_cnt), 64'd0);
    check("t5_clr_drop", 64'(stat_drop_cnt), 64'd0);
    check("t5_clr_gap", 64'(stat_gap_min), 64'hFFFF_FFFF);
    exp_wp = 0;
    send_beats(4, 1'b1, 1'b1);
    idle(1);
    send_beats(2, 1'b0, 1'b1);
    cfg_start = 32'd0;
    @(negedge clk);
    check("t5_stop_idle", 64'(stat_state), 64'd0);
    check("t5_stop_wptr", 64'(stat_wptr), 64'd6);
    check("t5_stop_pkt", 64'(stat_pkt_cnt), 64'd1);
    check("t5_stop_gap", 64'(stat_gap_min), 64'd1);

    // ---- arm mid-packet (source at beat 2 of 4) ----
    cfg_num   = 32'd1;
    cfg_start = 32'd1;
    @(negedge clk);
    check("t2_armed", 64'(stat_state), 64'd1);
    send_beats(2, 1'b1, 1'b0);
    check("t2_still_armed", 64'(stat_state), 64'd1);
    check("t2_ign_wptr", 64'(stat_wptr), 64'd0);
    idle(3);
    exp_wp = 0;
    send_beats(4, 1'b1, 1'b1);
    check("t2_done", 64'(stat_state), 64'd3);
    check("t2_wptr", 64'(stat_wptr), 64'd4);
    check("t2_pkt", 64'(stat_pkt_cnt), 64'd1);
    cbus_rd(0, 0);
    cbus_rd(0, 8);
    cbus_rd(3, 5);

    // ---- fill RAM: 1100 beats back-to-back, 11-beat packets ----
    cfg_start = 32'd0;
    @(negedge clk);
    cfg_num   = 32'd0;
    cfg_start = 32'd1;
    @(negedge clk);
    check("t3_armed", 64'(stat_state), 64'd1);
    exp_wp = 0;
    for (int p = 0; p < 100; p++) send_beats(11, 1'b1, 1'b1);
    check("t3_done", 64'(stat_state), 64'd3);
    check("t3_wptr", 64'(stat_wptr), 64'd1024);
    check("t3_drop", 64'(stat_drop_cnt), 64'd76);
    check("t3_pkt", 64'(stat_pkt_cnt), 64'd93);
    check("t3_gap", 64'(stat_gap_min), 64'd0);
    cbus_rd(1023, 0);
    cbus_rd(1023, 8);
    cbus_rd(0, 2);
    cbus_rd(512, 7);
    cbus_rd(700, 63);

    // ---- reset mid-packet ----
    cfg_start = 32'd0;
    @(negedge clk);
    cfg_start = 32'd1;
    @(negedge clk);
    send_beats(2, 1'b0, 1'b0);
    check("t6_pre_wptr", 64'(stat_wptr), 64'd2);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    check("t6_rdy", 64'(bus.rx_pkt_rdy), 64'd1);
    @(negedge clk);
    check("t6_rearm", 64'(stat_state), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
